// File: rtl/seq_det_pkg.sv
// Shared definitions for the overlapping "1101" detector: state encoding and the
// single next-state/match function used by every detector instance.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

    typedef struct packed {
        det_state_t next;
        logic       match;
    } det_step_t;

    // One detector step; match is reported on the transition that completes "1101".
    function automatic det_step_t det_step(input det_state_t cur, input logic din);
        det_step_t r;
        r.next  = S0;
        r.match = (cur == S3) && din;
        unique case (cur)
            S0:      r.next = din ? S1 : S0;
            S1:      r.next = din ? S2 : S0;
            S2:      r.next = din ? S2 : S3;
            S3:      r.next = din ? S1 : S0;
            default: r.next = S0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search starts at the pointer and
// wraps; the pointer moves to one past the granted requester.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic          gnt_any,
    output logic [CW-1:0] gnt_idx
);

    localparam logic [CW:0]   NCH_W = (CW+1)'(NCH);
    localparam logic [CW-1:0] LAST  = CW'(NCH - 1);

    logic [CW-1:0] ptr_reg;
    logic [CW-1:0] ptr_next;
    logic [CW:0]   cand;

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 0; off < NCH; off++) begin
            // Sum is one bit wider so the wrap works for non-power-of-two NCH.
            cand = {1'b0, ptr_reg} + (CW+1)'(off);
            if (cand >= NCH_W) begin
                cand = cand - NCH_W;
            end
            if (!gnt_any && req[cand[CW-1:0]]) begin
                gnt_any              = 1'b1;
                gnt_idx              = cand[CW-1:0];
                gnt[cand[CW-1:0]]    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_any) begin
            ptr_next = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// One "1101" detection engine time-shared across NCH serial channels, each with a
// one-bit holding buffer and saved context. Optional: SEQ_DET_MATCH_COUNT_EN.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_bit,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] ch_clear,
    output logic           match_valid,
    output logic [CW-1:0]  match_ch,
    output logic           busy
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    input  logic [CW-1:0]  cnt_sel,
    output logic [7:0]     cnt_out
`endif
);

    logic [NCH-1:0] pend_reg;
    logic [NCH-1:0] pend_next;
    logic [NCH-1:0] pbit_reg;
    logic [NCH-1:0] pbit_next;
    det_state_t     ctx_reg  [NCH];
    det_state_t     ctx_next [NCH];

    logic           match_valid_reg;
    logic [CW-1:0]  match_ch_reg;

    logic [NCH-1:0] req;
    logic [NCH-1:0] gnt;
    logic           gnt_any;
    logic [CW-1:0]  gnt_idx;
    logic [NCH-1:0] accept;
    det_step_t      step;
    logic           match_hit;

    // A channel being cleared must not be served this cycle.
    assign req = pend_reg & ~ch_clear;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    assign step      = det_step(ctx_reg[gnt_idx], pbit_reg[gnt_idx]);
    assign match_hit = gnt_any & step.match;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign in_ready[gi]  = (~pend_reg[gi] | gnt[gi]) & ~ch_clear[gi];
        assign accept[gi]    = in_valid[gi] & in_ready[gi];
        assign pend_next[gi] = ch_clear[gi] ? 1'b0 :
                               accept[gi]   ? 1'b1 :
                               gnt[gi]      ? 1'b0 : pend_reg[gi];
        assign pbit_next[gi] = accept[gi] ? in_bit[gi] : pbit_reg[gi];
        assign ctx_next[gi]  = ch_clear[gi] ? S0 :
                               gnt[gi]      ? step.next : ctx_reg[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg        <= '0;
            pbit_reg        <= '0;
            match_valid_reg <= 1'b0;
            match_ch_reg    <= '0;
            for (int i = 0; i < NCH; i++) begin
                ctx_reg[i] <= S0;
            end
        end else begin
            pend_reg        <= pend_next;
            pbit_reg        <= pbit_next;
            match_valid_reg <= match_hit;
            if (match_hit) begin
                match_ch_reg <= gnt_idx;
            end
            for (int i = 0; i < NCH; i++) begin
                ctx_reg[i] <= ctx_next[i];
            end
        end
    end

    assign match_valid = match_valid_reg;
    assign match_ch    = match_ch_reg;
    assign busy        = |pend_reg;

`ifdef SEQ_DET_MATCH_COUNT_EN
    localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

    logic [7:0] cnt_reg  [NCH];
    logic [7:0] cnt_next [NCH];

    // Counters saturate at 255; a channel clear overrides a same-cycle increment.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
        assign cnt_next[gi] = ch_clear[gi] ? 8'd0 :
                              (match_hit && gnt[gi] && cnt_reg[gi] != 8'hFF) ?
                              cnt_reg[gi] + 8'd1 : cnt_reg[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_reg[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign cnt_out = ({1'b0, cnt_sel} < NCH_W) ? cnt_reg[cnt_sel] : 8'd0;
`endif

endmodule
